// File: rtl/mutex_client_master.sv
// Avalon-MM master that acquires/releases a hardware mutex for one local requester.
// State table:
//   IDLE     | waiting for acquire_req
//   ACQ_WR   | writing {owner,lock} to the mutex register
//   ACQ_RD   | reading the register back
//   ACQ_WAIT | waiting for readback data
//   BACKOFF  | idle wait after a lost attempt
//   HELD     | mutex confirmed owned
//   REL_WR   | writing {owner,0} to release
//   FAIL     | retries exhausted, one-cycle acq_fail
module mutex_client_master #(
  parameter logic [15:0] OWNER_ID       = 16'h0001,
  parameter logic [15:0] LOCK_VALUE     = 16'h0001,
  parameter int unsigned BACKOFF_CYCLES = 8,
  parameter int unsigned MAX_RETRIES    = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        acquire_req,
  input  logic        release_req,
  output logic        granted,
  output logic        busy,
  output logic        acq_fail,
  output logic        avm_address,
  output logic        avm_chipselect,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  input  logic        avm_readdatavalid
);

  localparam logic [31:0] LOCK_WORD     = {OWNER_ID, LOCK_VALUE};
  localparam logic [31:0] RELEASE_WORD  = {OWNER_ID, 16'h0000};
  localparam logic [7:0]  BACKOFF_LOAD  = 8'(BACKOFF_CYCLES);
  localparam logic [7:0]  MAX_RETRY_CNT = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    IDLE,
    ACQ_WR,
    ACQ_RD,
    ACQ_WAIT,
    BACKOFF,
    HELD,
    REL_WR,
    FAIL
  } state_t;

  state_t     state, next_state;
  logic [7:0] retry_cnt, retry_nxt;
  logic [7:0] backoff_cnt, backoff_nxt;
  logic [7:0] retry_inc;
  logic       check_en;

  assign retry_inc   = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
  assign avm_address = 1'b0;

  always_comb begin
    next_state  = state;
    retry_nxt   = retry_cnt;
    backoff_nxt = backoff_cnt;
    check_en    = 1'b0;
    case (state)
      IDLE: begin
        if (acquire_req) begin
          retry_nxt  = 8'd0;
          next_state = ACQ_WR;
        end
      end
      ACQ_WR: begin
        if (!avm_waitrequest) next_state = ACQ_RD;
      end
      ACQ_RD: begin
        if (!avm_waitrequest) begin
          if (avm_readdatavalid) check_en = 1'b1;
          else                   next_state = ACQ_WAIT;
        end
      end
      ACQ_WAIT: begin
        if (avm_readdatavalid) check_en = 1'b1;
      end
      BACKOFF: begin
        if (backoff_cnt <= 8'd1) begin
          backoff_nxt = 8'd0;
          next_state  = ACQ_WR;
        end else begin
          backoff_nxt = backoff_cnt - 8'd1;
        end
      end
      HELD: begin
        if (release_req) next_state = REL_WR;
      end
      REL_WR: begin
        if (!avm_waitrequest) next_state = IDLE;
      end
      FAIL: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase

    // readback compare shared by the normal and same-cycle readdatavalid paths
    if (check_en) begin
      if (avm_readdata == LOCK_WORD) begin
        next_state = HELD;
      end else begin
        retry_nxt = retry_inc;
        if ((MAX_RETRIES != 0) && (retry_inc == MAX_RETRY_CNT)) begin
          next_state = FAIL;
        end else begin
          backoff_nxt = BACKOFF_LOAD;
          next_state  = BACKOFF;
        end
      end
    end
  end

  // outputs are registered from next_state so they line up with the state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      retry_cnt      <= 8'd0;
      backoff_cnt    <= 8'd0;
      granted        <= 1'b0;
      busy           <= 1'b0;
      acq_fail       <= 1'b0;
      avm_chipselect <= 1'b0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= 32'h0000_0000;
    end else begin
      state          <= next_state;
      retry_cnt      <= retry_nxt;
      backoff_cnt    <= backoff_nxt;
      granted        <= (next_state == HELD);
      busy           <= (next_state != IDLE) && (next_state != HELD);
      acq_fail       <= (next_state == FAIL);
      avm_chipselect <= (next_state == ACQ_WR) || (next_state == ACQ_RD) ||
                        (next_state == REL_WR);
      avm_read       <= (next_state == ACQ_RD);
      avm_write      <= (next_state == ACQ_WR) || (next_state == REL_WR);
      if (next_state == ACQ_WR)      avm_writedata <= LOCK_WORD;
      else if (next_state == REL_WR) avm_writedata <= RELEASE_WORD;
      else                           avm_writedata <= 32'h0000_0000;
    end
  end

endmodule
